dbus_fabric_n: RTL and testbench

DBUS_FABRIC_N -- requirements
Module: dbus_fabric_n

---
 rtl/dbus_fabric_pkg.sv | 42 ++++
 rtl/dbus_addr_decoder.sv | 40 ++++
 rtl/dbus_fabric_n.sv | 158 +++++++++++++++
 tb/tb_dbus_fabric_n.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_fabric_pkg.sv
// Shared types and constants for the single-outstanding peripheral bus fabric.
package dbus_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } type_dbus_fab_state_e;

  localparam int          DEF_VEC_W = 1024;
  localparam logic [63:0] DEF_BASE0 = 64'h0000_0000_9000_0000;
  localparam logic [63:0] DEF_STEP  = 64'h0000_0000_0001_0000;
  localparam logic [63:0] DEF_MASK  = 64'h0000_0000_FFFF_0000;

  function automatic int slot_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Default map packs slot i at bits [i*aw +: aw]; the caller casts to its width.
  function automatic logic [DEF_VEC_W-1:0] def_peri_base(input int n, input int aw);
    logic [DEF_VEC_W-1:0] v;
    logic [63:0]          lim;
    v   = '0;
    lim = (64'd1 << aw) - 64'd1;
    for (int i = 0; i < n; i++) begin
      v = v | (DEF_VEC_W'((DEF_BASE0 + DEF_STEP * 64'(i)) & lim) << (i * aw));
    end
    return v;
  endfunction

  function automatic logic [DEF_VEC_W-1:0] def_peri_mask(input int n, input int aw);
    logic [DEF_VEC_W-1:0] v;
    logic [63:0]          lim;
    v   = '0;
    lim = (64'd1 << aw) - 64'd1;
    for (int i = 0; i < n; i++) begin
      v = v | (DEF_VEC_W'(DEF_MASK & lim) << (i * aw));
    end
    return v;
  endfunction

endpackage

// File: rtl/dbus_addr_decoder.sv
// Base/mask address decoder; overlapping windows resolve to the lowest slot index.
module dbus_addr_decoder
  import dbus_fabric_pkg::*;
#(
  parameter int NUM_PERI = 8,
  parameter int ADDR_W   = 32,
  parameter logic [NUM_PERI*ADDR_W-1:0] PERI_BASE =
    (NUM_PERI*ADDR_W)'(def_peri_base(NUM_PERI, ADDR_W)),
  parameter logic [NUM_PERI*ADDR_W-1:0] PERI_MASK =
    (NUM_PERI*ADDR_W)'(def_peri_mask(NUM_PERI, ADDR_W))
) (
  input  logic [ADDR_W-1:0]                 addr,
  output logic [NUM_PERI-1:0]               one_hot,
  output logic                              hit,
  output logic [slot_idx_w(NUM_PERI)-1:0]   idx
);

  localparam int IDX_W = slot_idx_w(NUM_PERI);

  logic [NUM_PERI-1:0] match;

  // Raw per-slot window match.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_PERI; i++) begin
      match[i] = ((addr ^ PERI_BASE[i*ADDR_W +: ADDR_W]) & PERI_MASK[i*ADDR_W +: ADDR_W]) == '0;
    end
  end

  // Isolating the lowest set bit gives the priority winner directly.
  always_comb begin
    hit     = |match;
    one_hot = match & (~match + NUM_PERI'(1'b1));
    idx     = '0;
    for (int i = NUM_PERI - 1; i >= 0; i--) begin
      idx = match[i] ? IDX_W'(i) : idx;
    end
  end

endmodule

// File: rtl/dbus_fabric_n.sv
// LSU-to-N-peripheral bus fabric, one transaction in flight.
// Optional WAIT timeout is enabled by defining DBUS_TIMEOUT_EN.
module dbus_fabric_n
  import dbus_fabric_pkg::*;
#(
  parameter int NUM_PERI = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter logic [NUM_PERI*ADDR_W-1:0] PERI_BASE =
    (NUM_PERI*ADDR_W)'(def_peri_base(NUM_PERI, ADDR_W)),
  parameter logic [NUM_PERI*ADDR_W-1:0] PERI_MASK =
    (NUM_PERI*ADDR_W)'(def_peri_mask(NUM_PERI, ADDR_W)),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic                         w_en_i,
  input  logic [DATA_W-1:0]            w_data_i,
  input  logic [DATA_W/8-1:0]          byte_en_i,
  output logic                         ack_o,
  output logic [DATA_W-1:0]            r_data_o,
  output logic                         err_o,
  output logic [NUM_PERI-1:0]          peri_sel_o,
  output logic [ADDR_W-1:0]            peri_addr_o,
  output logic                         peri_w_en_o,
  output logic [DATA_W-1:0]            peri_w_data_o,
  output logic [DATA_W/8-1:0]          peri_byte_en_o,
  input  logic [NUM_PERI-1:0]          peri_ack_i,
  input  logic [NUM_PERI*DATA_W-1:0]   peri_r_data_i
);

  localparam int IDX_W = slot_idx_w(NUM_PERI);

  type_dbus_fab_state_e state, state_nxt;
  logic [NUM_PERI-1:0]  dec_one_hot, sel_nxt;
  logic                 dec_hit;
  logic [IDX_W-1:0]     dec_idx, slot_idx;
  logic                 ack_nxt, err_nxt, load, sel_ack, timeout_hit;
  logic [DATA_W-1:0]    rdata_nxt, sel_data;

  dbus_addr_decoder #(
    .NUM_PERI  (NUM_PERI),
    .ADDR_W    (ADDR_W),
    .PERI_BASE (PERI_BASE),
    .PERI_MASK (PERI_MASK)
  ) u_dec (
    .addr    (addr_i),
    .one_hot (dec_one_hot),
    .hit     (dec_hit),
    .idx     (dec_idx)
  );

  // Only the selected slot's ack counts; the rest are masked out.
  assign sel_ack  = |(peri_ack_i & peri_sel_o);
  assign sel_data = peri_r_data_i[slot_idx*DATA_W +: DATA_W];

`ifdef DBUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt;

  // Counts WAIT cycles; held at zero elsewhere so every WAIT entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-response logic.
  always_comb begin
    state_nxt = state;
    sel_nxt   = peri_sel_o;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    rdata_nxt = '0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (req_i) begin
          load = 1'b1;
          if (dec_hit) begin
            state_nxt = WAIT;
            sel_nxt   = dec_one_hot;
          end else begin
            state_nxt = RESP;
            ack_nxt   = 1'b1;
            err_nxt   = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        // A real ack beats an expiring timeout in the same cycle.
        if (sel_ack) begin
          state_nxt = RESP;
          sel_nxt   = '0;
          ack_nxt   = 1'b1;
          rdata_nxt = peri_w_en_o ? '0 : sel_data;
        end else if (timeout_hit) begin
          state_nxt = RESP;
          sel_nxt   = '0;
          ack_nxt   = 1'b1;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
      end
    endcase
  end

  // State, response and peripheral-side registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      peri_sel_o     <= '0;
      ack_o          <= 1'b0;
      err_o          <= 1'b0;
      r_data_o       <= '0;
      peri_addr_o    <= '0;
      peri_w_en_o    <= 1'b0;
      peri_w_data_o  <= '0;
      peri_byte_en_o <= '0;
      slot_idx       <= '0;
    end else begin
      state      <= state_nxt;
      peri_sel_o <= sel_nxt;
      ack_o      <= ack_nxt;
      err_o      <= err_nxt;
      r_data_o   <= rdata_nxt;
      if (load) begin
        peri_addr_o    <= addr_i;
        peri_w_en_o    <= w_en_i;
        peri_w_data_o  <= w_data_i;
        peri_byte_en_o <= byte_en_i;
        slot_idx       <= dec_idx;
      end
    end
  end

endmodule

// File: tb/tb_dbus_fabric_n.sv
// Randomized self-checking bench for dbus_fabric_n against an address-map reference model.
module tb_dbus_fabric_n;

  logic         clk = 1'b0;
  logic         rst;
  logic         req, req2, w_en;
  logic [31:0]  addr, w_data;
  logic [3:0]   byte_en;
  logic         ack, err, peri_w_en;
  logic [31:0]  r_data, peri_addr, peri_w_data;
  logic [7:0]   peri_sel, peri_ack;
  logic [3:0]   peri_byte_en;
  logic [255:0] peri_r_data;
  logic         ack2, err2, peri_w_en2;
  logic [31:0]  r_data2, peri_addr2, peri_w_data2;
  logic [7:0]   peri_sel2, peri_ack2;
  logic [3:0]   peri_byte_en2;
  int passed = 0;
  int total  = 0;

  localparam logic [255:0] OVL_BASE = {32'h9007_0000, 32'h9006_0000, 32'h9005_0000, 32'h9001_0000,
                                       32'h9003_0000, 32'h9002_0000, 32'h9001_0000, 32'h9000_0000};

  always #5 clk = ~clk;

  dbus_fabric_n dut (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .w_en_i(w_en), .w_data_i(w_data),
    .byte_en_i(byte_en), .ack_o(ack), .r_data_o(r_data), .err_o(err), .peri_sel_o(peri_sel),
    .peri_addr_o(peri_addr), .peri_w_en_o(peri_w_en), .peri_w_data_o(peri_w_data),
    .peri_byte_en_o(peri_byte_en), .peri_ack_i(peri_ack), .peri_r_data_i(peri_r_data));

  dbus_fabric_n #(.PERI_BASE(OVL_BASE)) dut_ovl (
    .clk(clk), .rst(rst), .req_i(req2), .addr_i(addr), .w_en_i(w_en), .w_data_i(w_data),
    .byte_en_i(byte_en), .ack_o(ack2), .r_data_o(r_data2), .err_o(err2), .peri_sel_o(peri_sel2),
    .peri_addr_o(peri_addr2), .peri_w_en_o(peri_w_en2), .peri_w_data_o(peri_w_data2),
    .peri_byte_en_o(peri_byte_en2), .peri_ack_i(peri_ack2), .peri_r_data_i(peri_r_data));

  // Reference address map: slot i owns 0x9000_0000 + i*64K; lowest matching slot wins.
  function automatic int exp_slot(input logic [31:0] a, input bit ovl);
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      b = 32'h9000_0000 + 32'(i) * 32'h0001_0000;
      if (ovl && i == 4) b = 32'h9001_0000;
      if ((a & 32'hFFFF_0000) == (b & 32'hFFFF_0000)) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request to completion and reports what the DUT did.
  task automatic run_txn(input logic [31:0] a, input bit we, input logic [31:0] wd,
                         input logic [3:0] be, input int dly, input logic [31:0] ad,
                         input logic [7:0] spur, output logic [7:0] sel_seen,
                         output int ack_cyc, output logic [31:0] rd, output bit er,
                         output bit stable, output bit quiet);
    int slot, waits;
    logic [7:0] spur_m;
    slot = exp_slot(a, 1'b0);
    sel_seen = '0; ack_cyc = -1; rd = '0; er = 1'b0; stable = 1'b1; quiet = 1'b1; waits = 0;
    for (int i = 0; i < 8; i++) peri_r_data[i*32 +: 32] = $urandom;
    if (slot >= 0) peri_r_data[slot*32 +: 32] = ad;
    spur_m = (slot >= 0) ? (spur & ~(8'd1 << slot)) : spur;
    addr = a; w_en = we; w_data = wd; byte_en = be; req = 1'b1; peri_ack = spur_m;
    for (int cyc = 1; cyc <= 200 && ack_cyc < 0; cyc++) begin
      tick();
      if (ack) begin
        ack_cyc = cyc; rd = r_data; er = err;
      end else if (err || r_data != 32'd0) begin
        quiet = 1'b0;
      end
      if (peri_sel != 8'd0) begin
        if (sel_seen == 8'd0) sel_seen = peri_sel;
        else if (peri_sel != sel_seen) stable = 1'b0;
        if (peri_addr !== a || peri_w_en !== we || peri_w_data !== wd || peri_byte_en !== be)
          stable = 1'b0;
      end
      peri_ack = spur_m;
      if (peri_sel != 8'd0 && slot >= 0 && !ack) begin
        if (waits == dly) peri_ack[slot] = 1'b1;
        waits++;
      end
    end
    req = 1'b0; peri_ack = '0;
    tick();
    if (ack || err || r_data != 32'd0 || peri_sel != 8'd0) quiet = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; req2 = 1'b0; addr = 32'h9000_0000; w_en = 1'b1;
    w_data = 32'hFFFF_FFFF; byte_en = 4'hF; peri_ack = 8'hFF; peri_ack2 = 8'h00;
    peri_r_data = '1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ack, err, r_data, peri_sel, peri_addr, peri_w_en, peri_w_data, peri_byte_en} !== '0)
      $display("FAIL reset_outputs: got %h required 0",
               {ack, err, r_data, peri_sel, peri_addr, peri_w_en, peri_w_data, peri_byte_en});
    else passed++;
    req = 1'b0; peri_ack = '0; rst = 1'b0;
    tick();
  endtask

  task automatic test_read_basic();
    logic [7:0] s; int c; logic [31:0] d; bit e, st, q;
    run_txn(32'h9003_0004, 1'b0, 32'd0, 4'hF, 0, 32'hCAFE_F00D, 8'h00, s, c, d, e, st, q);
    total++; if (s !== 8'b0000_1000) $display("FAIL read_sel: got %b required 00001000", s); else passed++;
    total++; if (c != 2) $display("FAIL read_latency: got %0d required 2", c); else passed++;
    total++; if (d !== 32'hCAFE_F00D) $display("FAIL read_data: got %h required cafef00d", d); else passed++;
    total++; if (e !== 1'b0 || !q) $display("FAIL read_err_quiet: err %b quiet %b required 0/1", e, q); else passed++;
  endtask

  task automatic test_write_wait();
    logic [7:0] s; int c; logic [31:0] d; bit e, st, q;
    run_txn(32'h9000_0010, 1'b1, 32'h1234_5678, 4'b0011, 5, 32'hDEAD_BEEF, 8'h00, s, c, d, e, st, q);
    total++; if (s !== 8'b0000_0001) $display("FAIL write_sel: got %b required 00000001", s); else passed++;
    total++; if (c != 7) $display("FAIL write_latency: got %0d required 7", c); else passed++;
    total++; if (!st) $display("FAIL write_stable: peri outputs changed during WAIT, required stable"); else passed++;
    total++; if (d !== 32'd0 || e !== 1'b0) $display("FAIL write_resp: data %h err %b required 0/0", d, e); else passed++;
  endtask

  task automatic test_unmapped();
    logic [7:0] s; int c; logic [31:0] d; bit e, st, q;
    run_txn(32'h8000_0000, 1'b0, 32'd0, 4'hF, 0, 32'd0, 8'hFF, s, c, d, e, st, q);
    total++; if (s !== 8'd0) $display("FAIL miss_sel: got %b required 0", s); else passed++;
    total++; if (c != 1) $display("FAIL miss_latency: got %0d required 1", c); else passed++;
    total++; if (e !== 1'b1 || d !== 32'd0) $display("FAIL miss_resp: err %b data %h required 1/0", e, d); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] s; int c1, c2; logic [31:0] d1, d2; bit e, st, q;
    run_txn(32'h9006_0100, 1'b0, 32'd0, 4'hF, 0, 32'h6666_0001, 8'h00, s, c1, d1, e, st, q);
    run_txn(32'h9007_0200, 1'b0, 32'd0, 4'hF, 2, 32'h7777_0002, 8'h00, s, c2, d2, e, st, q);
    total++; if (c1 != 2 || c2 != 4) $display("FAIL b2b_latency: got %0d,%0d required 2,4", c1, c2); else passed++;
    total++; if (d1 !== 32'h6666_0001 || d2 !== 32'h7777_0002)
      $display("FAIL b2b_data: got %h,%h required 66660001,77770002", d1, d2); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] s, spur, esel; int c, r, dly, slot, ecyc; logic [31:0] d, a, wd, ad, ed;
    logic [3:0] be; bit e, st, q, we;
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 8);
      if (r == 8) a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
      else a = 32'h9000_0000 + (32'(r) << 16) + ($urandom & 32'h0000_FFFC);
      we = 1'($urandom_range(0, 1)); wd = $urandom; ad = $urandom; be = 4'($urandom);
      dly = $urandom_range(0, 4); spur = 8'($urandom);
      run_txn(a, we, wd, be, dly, ad, spur, s, c, d, e, st, q);
      slot = exp_slot(a, 1'b0);
      esel = (slot >= 0) ? (8'd1 << slot) : 8'd0;
      ecyc = (slot >= 0) ? dly + 2 : 1;
      ed   = (slot < 0 || we) ? 32'd0 : ad;
      total++; if (s !== esel) $display("FAIL rand%0d_sel: got %b required %b", n, s, esel); else passed++;
      total++; if (c != ecyc) $display("FAIL rand%0d_latency: got %0d required %0d", n, c, ecyc); else passed++;
      total++; if (d !== ed) $display("FAIL rand%0d_data: got %h required %h", n, d, ed); else passed++;
      total++; if (e !== (slot < 0)) $display("FAIL rand%0d_err: got %b required %b", n, e, slot < 0); else passed++;
      total++; if (!st || !q) $display("FAIL rand%0d_protocol: stable %b quiet %b required 1/1", n, st, q); else passed++;
    end
  endtask

  task automatic test_reset_in_wait();
    logic [7:0] s; int c; logic [31:0] d; bit e, st, q, late;
    addr = 32'h9002_0000; w_en = 1'b0; req = 1'b1; peri_ack = '0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    total++;
    if ({ack, err, r_data, peri_sel, peri_addr, peri_w_en, peri_w_data, peri_byte_en} !== '0)
      $display("FAIL rst_wait_outputs: got %h required 0",
               {ack, err, r_data, peri_sel, peri_addr, peri_w_en, peri_w_data, peri_byte_en});
    else passed++;
    #1;
    rst = 1'b0; req = 1'b0;
    peri_ack = 8'b0000_0100; peri_r_data[2*32 +: 32] = 32'h5555_AAAA;
    late = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack || peri_sel != 8'd0) late = 1'b1;
    end
    peri_ack = '0;
    total++; if (late) $display("FAIL rst_late_ack: got ack/sel after reset, required none"); else passed++;
    run_txn(32'h9002_0008, 1'b0, 32'd0, 4'hF, 1, 32'h0BAD_F00D, 8'h00, s, c, d, e, st, q);
    total++; if (c != 3 || d !== 32'h0BAD_F00D)
      $display("FAIL rst_recover: latency %0d data %h required 3/0badf00d", c, d); else passed++;
  endtask

  task automatic test_overlap();
    logic [7:0] esel;
    esel = 8'd1 << exp_slot(32'h9001_0040, 1'b1);
    addr = 32'h9001_0040; w_en = 1'b0; req2 = 1'b1; peri_ack2 = 8'b0001_0000;
    peri_r_data[1*32 +: 32] = 32'hA5A5_0001; peri_r_data[4*32 +: 32] = 32'hA5A5_0004;
    tick();
    total++; if (peri_sel2 !== esel) $display("FAIL ovl_sel: got %b required %b", peri_sel2, esel); else passed++;
    peri_ack2 = 8'b0001_0010;
    tick();
    total++; if (ack2 !== 1'b1 || r_data2 !== 32'hA5A5_0001)
      $display("FAIL ovl_resp: ack %b data %h required 1/a5a50001", ack2, r_data2); else passed++;
    req2 = 1'b0; peri_ack2 = '0;
    tick();
  endtask

`ifdef DBUS_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] s; int c; logic [31:0] d; bit e, st, q;
    run_txn(32'h9005_0000, 1'b0, 32'd0, 4'hF, 1000, 32'h1111_2222, 8'b0000_0100, s, c, d, e, st, q);
    total++; if (c != 65) $display("FAIL timeout_latency: got %0d required 65", c); else passed++;
    total++; if (e !== 1'b1 || d !== 32'd0) $display("FAIL timeout_resp: err %b data %h required 1/0", e, d); else passed++;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_basic();
    test_write_wait();
    test_unmapped();
    test_back_to_back();
    test_random();
    test_reset_in_wait();
    test_overlap();
`ifdef DBUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
